bsg_fifo_pkt_commit_gen: RTL
============================

Name: bsg_fifo_pkt_commit_gen

Overview:
- Packet-admission stage placed directly upstream of the store-and-forward FIFO.
- Passes packet beats through with valid/ready, and checks each packet for error flags, runt length and overlength.
- After the final beat is enqueued, issues exactly one commit_v_o pulse, with commit_drop_o saying whether the FIFO keeps or discards the speculatively written beats.
- The downstream FIFO therefore only ever exposes whole, good packets to its reader.

Parameters:
- width_p, none (required), beat data width.
- min_len_p, 1, minimum legal packet length in beats; shorter packets are dropped.
- max_len_p, none (required), maximum legal length in beats; must be <= FIFO depth and >= min_len_p.
- len_width_lp, localparam = clog2(max_len_p+1), beat counter width.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- data_i  in  width_p  upstream beat data.
- last_i  in  1  beat is final beat of packet.
- err_i  in  1  beat carries an error flag (sticky for the packet).
- v_i  in  1  upstream valid.
- ready_o  out  1  upstream ready.
- data_o  out  width_p  beat data to FIFO (combinational copy of data_i).
- v_o  out  1  beat valid to FIFO.
- ready_i  in  1  FIFO ready.
- commit_v_o  out  1  single-cycle commit strobe.
- commit_drop_o  out  1  qualifies commit_v_o: 1 = discard packet, 0 = keep.
- pkt_good_cnt_o  out  32  committed packet count (see Optional Feature).
- pkt_drop_cnt_o  out  32  dropped packet count (see Optional Feature).

Behaviour:
- Handshake: beat accepted when v_i & ready_o.
- States: PASS, DISCARD, COMMIT. Reset state is PASS; len_r=0; bad_r=0; all outputs 0 except ready_o, which follows ready_i in PASS.
- PASS:
  - ready_o=ready_i; v_o=v_i.
  - Each accepted beat increments len_r.
  - bad_r |= err_i.
- Overlength: an accepted non-last beat that brings len_r to max_len_p moves to DISCARD and sets ovf_r.
- DISCARD:
  - ready_o=1; v_o=0, so beats are consumed and not written.
  - Stays in DISCARD until an accepted last_i beat, then goes to COMMIT with drop forced.
- Last beat accepted in PASS: the beat is enqueued, then go to COMMIT.
- COMMIT (exactly one cycle):
  - ready_o=0; v_o=0.
  - commit_v_o=1.
  - commit_drop_o = bad_r | ovf_r | (len_r < min_len_p), with len_r counting the last beat.
  - Clears len_r, bad_r and ovf_r, then returns to PASS.
- Latency:
  - Data path has zero latency: data_o=data_i, combinational.
  - commit_v_o is asserted exactly 1 cycle after the last-beat handshake.
- Single-beat packet (last_i on first beat): len=1, legal iff min_len_p<=1.
- A packet of exactly max_len_p beats, with last on beat max_len_p, is legal and never enters DISCARD.
- err_i on the last beat still drops the packet.
- Back-to-back packets incur one bubble cycle, the COMMIT state.
- Asynchronous reset mid-packet:
  - All state clears immediately.
  - No commit is issued for the partial packet; the downstream FIFO is reset by the same reset.
- Outputs commit_v_o and commit_drop_o are registered, with no combinational path from inputs.

Optional Feature:
- Macro: BSG_FIFO_PKT_COMMIT_GEN_STATS_EN.
- Defined:
  - Two 32-bit saturating counters increment on each commit_v_o pulse: pkt_good_cnt_o when drop=0, pkt_drop_cnt_o when drop=1.
  - Both reset to 0 and hold at 32'hFFFF_FFFF.
- Undefined: counters are not built, and both outputs are tied to 0.

Test Plan:
- 3-beat packet, err_i=0, min_len_p=1, max_len_p=8, ready_i=1:
  - 3 beats on v_o.
  - Cycle after the last beat: commit_v_o=1, commit_drop_o=0, ready_o=0.
- 2-beat packet with err_i=1 on beat 1: both beats forwarded; commit_v_o=1, commit_drop_o=1.
- 10-beat packet with max_len_p=8:
  - Beats 1-8 are forwarded.
  - Beats 9-10 are accepted with v_o=0.
  - One commit with drop=1 after beat 10.
- Runt with min_len_p=4: 2-beat packet -> commit_drop_o=1. Then a 4-beat packet -> commit_drop_o=0; the bubble cycle falls between them.
- ready_i held low for 5 cycles mid-packet:
  - ready_o=0 and len_r stays frozen.
  - On release, the remaining beats flow and a single commit follows.
- reset_ni asserted after beat 2 of 5: all outputs go 0 immediately with no commit. After release, a new 1-beat packet commits with drop=0. With STATS_EN defined, the good count reads 1.

Source files
------------

// File: rtl/bsg_fifo_pkt_commit_gen.sv
// ============================================================================
// Module   : bsg_fifo_pkt_commit_gen
// Purpose  : Packet admission ahead of a store-and-forward FIFO. Forwards beats,
//            then issues one keep/drop commit per packet (error, runt, overlength).
// Option   : BSG_FIFO_PKT_COMMIT_GEN_STATS_EN builds good/drop packet counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bsg_fifo_pkt_commit_gen #(
  parameter int width_p   = 8,
  parameter int min_len_p = 1,
  parameter int max_len_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [width_p-1:0] data_i,
  input  logic               last_i,
  input  logic               err_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               ready_i,
  output logic               commit_v_o,
  output logic               commit_drop_o,
  output logic [31:0]        pkt_good_cnt_o,
  output logic [31:0]        pkt_drop_cnt_o
);

  localparam int len_width_lp = $clog2(max_len_p + 1);
  localparam logic [len_width_lp-1:0] max_len_lp = len_width_lp'(max_len_p);
  localparam logic [len_width_lp-1:0] min_len_lp = len_width_lp'(min_len_p);

  typedef enum logic [1:0] {
    S_PASS    = 2'd0,
    S_DISCARD = 2'd1,
    S_COMMIT  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [len_width_lp-1:0] len_q, len_d;
  logic                    bad_q, bad_d;
  logic                    ovf_q, ovf_d;
  logic                    commit_v_q, commit_v_d;
  logic                    commit_drop_q, commit_drop_d;
  logic [len_width_lp-1:0] len_inc;

  // In PASS len_q never exceeds max_len_p-1, so the increment cannot wrap.
  assign len_inc = len_q + len_width_lp'(1);
  assign data_o  = data_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= S_PASS;
      len_q         <= '0;
      bad_q         <= 1'b0;
      ovf_q         <= 1'b0;
      commit_v_q    <= 1'b0;
      commit_drop_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      bad_q         <= bad_d;
      ovf_q         <= ovf_d;
      commit_v_q    <= commit_v_d;
      commit_drop_q <= commit_drop_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    bad_d         = bad_q;
    ovf_d         = ovf_q;
    commit_v_d    = 1'b0;
    commit_drop_d = 1'b0;
    ready_o       = 1'b0;
    v_o           = 1'b0;

    case (state_q)
      S_PASS: begin
        ready_o = ready_i;
        v_o     = v_i & reset_ni;
        if (v_i && ready_i) begin
          len_d = len_inc;
          bad_d = bad_q | err_i;
          if (last_i) begin
            state_d       = S_COMMIT;
            commit_v_d    = 1'b1;
            commit_drop_d = bad_q | err_i | ovf_q | (len_inc < min_len_lp);
          end else if (len_inc == max_len_lp) begin
            state_d = S_DISCARD;
            ovf_d   = 1'b1;
          end
        end
      end

      // Overlength tail: swallow beats without writing them into the FIFO.
      S_DISCARD: begin
        ready_o = 1'b1;
        if (v_i) begin
          bad_d = bad_q | err_i;
          if (last_i) begin
            state_d       = S_COMMIT;
            commit_v_d    = 1'b1;
            commit_drop_d = 1'b1;
          end
        end
      end

      S_COMMIT: begin
        len_d   = '0;
        bad_d   = 1'b0;
        ovf_d   = 1'b0;
        state_d = S_PASS;
      end

      default: begin
        state_d = S_PASS;
      end
    endcase
  end

  assign commit_v_o    = commit_v_q;
  assign commit_drop_o = commit_drop_q;

`ifdef BSG_FIFO_PKT_COMMIT_GEN_STATS_EN
  logic [31:0] good_cnt_q;
  logic [31:0] drop_cnt_q;

  // Saturating counters: hold at all-ones rather than wrapping.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      good_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else if (commit_v_q) begin
      if (!commit_drop_q && (good_cnt_q != 32'hFFFF_FFFF)) begin
        good_cnt_q <= good_cnt_q + 32'd1;
      end
      if (commit_drop_q && (drop_cnt_q != 32'hFFFF_FFFF)) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign pkt_good_cnt_o = good_cnt_q;
  assign pkt_drop_cnt_o = drop_cnt_q;
`else
  assign pkt_good_cnt_o = 32'd0;
  assign pkt_drop_cnt_o = 32'd0;
`endif

endmodule

`default_nettype wire
